// File: rtl/uart_pkg.sv
// Shared UART definitions: word-assembly FSM states and default word geometry.
package uart_pkg;

  // Word assembler FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } uart_word_state_e;

  // Default word geometry and inter-byte timeout (20 bit times at 16x oversampling).
  localparam int UART_NBYTES        = 4;
  localparam int UART_TIMEOUT_TICKS = 320;
  localparam int UART_TO_BITS       = 9;

endpackage

// File: rtl/uart_word_assembler.sv
// Assembles NBYTES received UART bytes, MSB-first, into one word. A partial
// word that goes TIMEOUT_TICKS baud ticks without a new byte is dropped and
// counted in a saturating drop counter.
module uart_word_assembler
  import uart_pkg::*;
#(
  parameter int NBYTES        = UART_NBYTES,
  parameter int TIMEOUT_TICKS = UART_TIMEOUT_TICKS,
  parameter int TO_BITS       = UART_TO_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_tick,
  input  logic                  rx_done_tick,
  input  logic [7:0]            rxbus,
  output logic [8*NBYTES-1:0]   rx_buf,
  output logic                  word_valid,
  output logic                  busy,
  output logic [7:0]            drop_cnt
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES + 1);

  localparam logic [CW-1:0]      CNT_LAST = CW'(NBYTES - 1);
  localparam logic [TO_BITS-1:0] TO_LAST  = TO_BITS'(TIMEOUT_TICKS - 1);

  uart_word_state_e     state_q, state_d;
  logic [W-1:0]         shreg_q, shreg_d;
  logic [W-1:0]         buf_q, buf_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [TO_BITS-1:0]   to_q, to_d;
  logic [7:0]           drop_q, drop_d;

  logic                 expire;
  logic                 restart;
  logic                 shift_in;
  logic [W-1:0]         shifted;
  logic [W-1:0]         first;

  // Expiry is driven by the tick alone; a byte arriving on the same tick
  // does not rescue the stale partial word, it starts a new one instead.
  assign expire   = (state_q == COLLECT) && s_tick && (to_q == TO_LAST);
  assign restart  = rx_done_tick && ((state_q != COLLECT) || expire);
  assign shift_in = rx_done_tick && (state_q == COLLECT) && !expire;
  assign shifted  = (shreg_q << 8) | W'(rxbus);
  assign first    = W'(rxbus);

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    drop_d  = drop_q;

    if (expire && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    if (restart) begin
      to_d = '0;
      if (NBYTES == 1) begin
        state_d = DONE;
        buf_d   = first;
        shreg_d = first;
        cnt_d   = '0;
      end else begin
        state_d = COLLECT;
        shreg_d = first;
        cnt_d   = CW'(1);
      end
    end else if (shift_in) begin
      shreg_d = shifted;
      to_d    = '0;
      if (cnt_q == CNT_LAST) begin
        state_d = DONE;
        buf_d   = shifted;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CW'(1);
      end
    end else if (expire) begin
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
      to_d    = '0;
    end else begin
      case (state_q)
        COLLECT: if (s_tick && (to_q != '1)) to_d = to_q + TO_BITS'(1);
        DONE:    state_d = IDLE;
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      drop_q  <= drop_d;
    end
  end

  assign rx_buf     = buf_q;
  assign word_valid = (state_q == DONE);
  assign busy       = (state_q == COLLECT);
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed bench for uart_word_assembler: a vector table for the main word and
// timeout flow, plus hand sequences for the multi-cycle corner cases.
module tb_uart_word_assembler;

  logic        clk;
  logic        reset;
  logic        s_tick;
  logic        rx_done_tick;
  logic [7:0]  rxbus;
  logic [31:0] rx_buf;
  logic        word_valid;
  logic        busy;
  logic [7:0]  drop_cnt;

  logic [31:0] rx_buf2;
  logic        word_valid2;
  logic        busy2;
  logic [7:0]  drop_cnt2;

  int checks = 0;
  int errors = 0;

  uart_word_assembler dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick),
    .rxbus        (rxbus),
    .rx_buf       (rx_buf),
    .word_valid   (word_valid),
    .busy         (busy),
    .drop_cnt     (drop_cnt)
  );

  // Short-timeout instance so drop counter saturation is reachable quickly.
  uart_word_assembler #(.NBYTES(4), .TIMEOUT_TICKS(4), .TO_BITS(3)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick),
    .rxbus        (rxbus),
    .rx_buf       (rx_buf2),
    .word_valid   (word_valid2),
    .busy         (busy2),
    .drop_cnt     (drop_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          gap;
    bit          send;
    logic [7:0]  b;
    logic        wv;
    logic        bsy;
    logic [31:0] rbuf;
    logic [7:0]  drop;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock with the given inputs; returns #1 after the edge.
  task automatic cyc(input logic st, input logic rd, input logic [7:0] b);
    s_tick = st; rx_done_tick = rd; rxbus = b;
    @(posedge clk); #1;
    s_tick = 1'b0; rx_done_tick = 1'b0; rxbus = 8'h00;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b0, 1'b1, b);
  endtask

  task automatic chk_out(input string name, input logic wv, input logic bsy,
                         input logic [31:0] rb, input logic [7:0] dr);
    chk({name, ".word_valid"}, 32'(word_valid), 32'(wv));
    chk({name, ".busy"},       32'(busy),       32'(bsy));
    chk({name, ".rx_buf"},     rx_buf,          rb);
    chk({name, ".drop_cnt"},   32'(drop_cnt),   32'(dr));
  endtask

  initial begin
    tbl[0]  = '{"w1_b0",   159, 1'b1, 8'hDE, 1'b0, 1'b1, 32'h0,        8'd0};
    tbl[1]  = '{"w1_b1",   159, 1'b1, 8'hAD, 1'b0, 1'b1, 32'h0,        8'd0};
    tbl[2]  = '{"w1_b2",   159, 1'b1, 8'hBE, 1'b0, 1'b1, 32'h0,        8'd0};
    tbl[3]  = '{"w1_b3",   159, 1'b1, 8'hEF, 1'b1, 1'b0, 32'hDEADBEEF, 8'd0};
    tbl[4]  = '{"w1_hold",   1, 1'b0, 8'h00, 1'b0, 1'b0, 32'hDEADBEEF, 8'd0};
    tbl[5]  = '{"p_b0",      0, 1'b1, 8'h11, 1'b0, 1'b1, 32'hDEADBEEF, 8'd0};
    tbl[6]  = '{"p_b1",      0, 1'b1, 8'h22, 1'b0, 1'b1, 32'hDEADBEEF, 8'd0};
    tbl[7]  = '{"p_319",   319, 1'b0, 8'h00, 1'b0, 1'b1, 32'hDEADBEEF, 8'd0};
    tbl[8]  = '{"p_320",     1, 1'b0, 8'h00, 1'b0, 1'b0, 32'hDEADBEEF, 8'd1};
    tbl[9]  = '{"w2_b0",     0, 1'b1, 8'h01, 1'b0, 1'b1, 32'hDEADBEEF, 8'd1};
    tbl[10] = '{"w2_b1",     0, 1'b1, 8'h02, 1'b0, 1'b1, 32'hDEADBEEF, 8'd1};
    tbl[11] = '{"w2_b2",     0, 1'b1, 8'h03, 1'b0, 1'b1, 32'hDEADBEEF, 8'd1};
    tbl[12] = '{"w2_b3",     0, 1'b1, 8'h04, 1'b1, 1'b0, 32'h01020304, 8'd1};

    reset = 1'b0; s_tick = 1'b0; rx_done_tick = 1'b0; rxbus = 8'h00;
    #2;
    chk_out("reset", 1'b0, 1'b0, 32'h0, 8'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Table: clean word, idle hold, timeout boundary, recovery word.
    for (int i = 0; i < 13; i++) begin
      ticks(tbl[i].gap);
      if (tbl[i].send) send(tbl[i].b);
      chk_out(tbl[i].name, tbl[i].wv, tbl[i].bsy, tbl[i].rbuf, tbl[i].drop);
    end

    // Timeout expiry coincident with a new byte: drop old, start fresh.
    send(8'hAA);
    ticks(319);
    chk_out("coin_pre", 1'b0, 1'b1, 32'h01020304, 8'd1);
    cyc(1'b1, 1'b1, 8'h55);
    chk_out("coin", 1'b0, 1'b1, 32'h01020304, 8'd2);
    chk("coin.byte_cnt", 32'(dut.cnt_q), 32'd1);
    send(8'h66); send(8'h77); send(8'h88);
    chk_out("coin_word", 1'b1, 1'b0, 32'h55667788, 8'd2);

    // Back-to-back words, first byte of word two lands in the DONE cycle.
    send(8'hCA); send(8'hFE); send(8'hF0); send(8'h0D);
    chk_out("b2b_w1", 1'b1, 1'b0, 32'hCAFEF00D, 8'd2);
    send(8'h12);
    chk_out("b2b_b0", 1'b0, 1'b1, 32'hCAFEF00D, 8'd2);
    send(8'h34); send(8'h56); send(8'h78);
    chk_out("b2b_w2", 1'b1, 1'b0, 32'h12345678, 8'd2);
    cyc(1'b0, 1'b0, 8'h00);
    chk("b2b_pulse", 32'(word_valid), 32'd0);

    // Asynchronous reset mid-word.
    send(8'h01); send(8'h02); send(8'h03);
    #2 reset = 1'b0;
    #1;
    chk_out("arst", 1'b0, 1'b0, 32'h0, 8'd0);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
    chk_out("arst_word", 1'b1, 1'b0, 32'hA1B2C3D4, 8'd0);

    // Drop counter saturation on the short-timeout instance.
    for (int n = 1; n <= 260; n++) begin
      send(8'h5A);
      ticks(4);
      if (n == 1)   chk("sat_first", 32'(drop_cnt2), 32'd1);
      if (n == 254) chk("sat_254",   32'(drop_cnt2), 32'd254);
      if (n == 255) chk("sat_255",   32'(drop_cnt2), 32'd255);
    end
    chk("sat_260", 32'(drop_cnt2), 32'd255);
    chk("sat_busy", 32'(busy2), 32'd0);
    chk("sat_main_drop", 32'(drop_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_word_assembler.md
UART_WORD_ASSEMBLER -- requirements
Module: uart_word_assembler

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, meaning bytes per word (word width = 8*NBYTES).
REQ-002 The block SHALL have parameter TIMEOUT_TICKS, default 320, meaning the maximum inter-byte gap in baud ticks (20 bit times at 16x oversampling).
REQ-003 The block SHALL have parameter TO_BITS, default 9, meaning the width of the timeout counter.
REQ-004 The block SHALL have port clk, input, 1, system clock.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port s_tick, input, 1, one-cycle baud oversampling tick.
REQ-007 The block SHALL have port rx_done_tick, input, 1, one-cycle strobe marking a valid received byte.
REQ-008 The block SHALL have port rxbus, input, 8, received byte, valid when rx_done_tick=1.
REQ-009 The block SHALL have port rx_buf, output, 8*NBYTES, last completed word, held until the next word completes.
REQ-010 The block SHALL have port word_valid, output, 1, one-cycle strobe on word completion.
REQ-011 The block SHALL have port busy, output, 1, high while a partial word is held.
REQ-012 The block SHALL have port drop_cnt, output, 8, saturating count of partial words discarded on timeout.

Function
REQ-013 Bytes SHALL be assembled MSB-first: the first byte after IDLE goes to bits [8*NBYTES-1 -: 8], and the last byte goes to bits [7:0].
REQ-014 The FSM SHALL have states IDLE, COLLECT and DONE.
REQ-015 IDLE -> COLLECT SHALL occur on rx_done_tick: load the byte into the shift register, set byte_cnt=1, clear the timeout counter.
REQ-016 In COLLECT, each rx_done_tick SHALL shift the byte in, increment byte_cnt and clear the timeout counter; when byte_cnt reaches NBYTES, go to DONE.
REQ-017 In COLLECT, each s_tick without rx_done_tick SHALL increment the timeout counter; on reaching TIMEOUT_TICKS, discard the partial word, increment drop_cnt (saturating at 255) and go to IDLE.
REQ-018 If the timeout expiry and rx_done_tick occur in the same cycle, the partial word SHALL be discarded (drop_cnt increments) and the new byte SHALL start a fresh word (byte_cnt=1, state COLLECT).
REQ-019 In DONE (exactly one cycle), rx_buf SHALL load the assembled word, word_valid=1, and the state SHALL return to IDLE; latency is one clk from the final rx_done_tick to word_valid and the rx_buf update.
REQ-020 An rx_done_tick arriving during DONE SHALL be accepted as byte 1 of the next word (transition to COLLECT); no byte is lost.
REQ-021 busy SHALL be 1 in COLLECT and 0 in IDLE and DONE.
REQ-022 rx_buf SHALL change only in DONE; discarded partial words never reach rx_buf.
REQ-023 The timeout counter SHALL saturate and never wrap; byte_cnt width SHALL be $clog2(NBYTES+1).

Reset
REQ-024 Asserting reset (low) SHALL asynchronously force: state IDLE, rx_buf=0, word_valid=0, busy=0, drop_cnt=0, byte_cnt=0, timeout counter=0, shift register=0.
REQ-025 Reset asserted mid-word SHALL discard the partial word without incrementing drop_cnt; after release, the next rx_done_tick starts a fresh word.

Structure
REQ-026 The FSM state enum and the default NBYTES/TIMEOUT_TICKS constants SHALL live in the shared package uart_pkg, also used by the transmit-side word buffer.
REQ-027 The block SHALL be a single module with no sub-modules; the timeout counter is inline; instantiation sits in the uart top beside uart_rx, with its output replacing the existing receive buffer path.

Verification
REQ-028 Bytes 0xDE,0xAD,0xBE,0xEF at 160-tick spacing -> one word_valid, rx_buf=32'hDEADBEEF, busy falls with DONE, drop_cnt=0.
REQ-029 Bytes 0x11,0x22, then 320 s_ticks silent -> drop_cnt=1, busy=0, rx_buf unchanged; then 0x01..0x04 -> rx_buf=32'h01020304.
REQ-030 Byte 0xAA, then at tick 320 a simultaneous 0x55 -> drop_cnt=1, byte_cnt=1; then 0x66,0x77,0x88 -> rx_buf=32'h55667788.
REQ-031 Back-to-back words with byte 1 of word 2 arriving in the DONE cycle -> two word_valid pulses, rx_buf=32'hCAFEF00D then 32'h12345678.
REQ-032 Reset pulsed low after 3 bytes -> all outputs 0 immediately (asynchronously); the next 4 bytes 0xA1,0xB2,0xC3,0xD4 -> rx_buf=32'hA1B2C3D4, drop_cnt=0.
REQ-033 Force 260 timeouts -> drop_cnt saturates at 255.
